gen1_arb8: RTL and testbench
============================

GEN1_ARB8 -- requirements
Module: gen1_arb8

Interface
REQ-001 Parameter TIMEOUT, default 15: BUSY cycles without memready before a bus exception is forced; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  high: new grants permitted.
REQ-005 mN_addr  input  32  byte address from requester N (N=0,1; likewise below).
REQ-006 mN_dout  input  8  write data from requester N.
REQ-007 mN_read, mN_write, mN_exec  input  1 each  strobes from requester N.
REQ-008 mN_din  output  8  read data to requester N.
REQ-009 mN_ready  output  1  completion to requester N.
REQ-010 mN_busx  output  1  bus exception to requester N.
REQ-011 xaddr  output  32;  xdout  output  8;  memread, memwrite, memexec  output  1 each  shared memory port.
REQ-012 xdin  input  8;  memready  input  1;  busx  input  1  shared memory port responses.
REQ-013 grant  output  2  one-hot owner indication; 2'b00 when no owner.

Function
REQ-014 States: IDLE, BUSY, DONE, ERR; state, owner, last-served pointer and timeout counter are registers.
REQ-015 Request N = mN_read | mN_write.
REQ-016 IDLE with enable=1 and any request: latch owner, go BUSY; grant visible the next cycle (1-cycle grant latency).
REQ-017 Both requesting in IDLE: grant the requester not last served; last-served resets to 1, so m0 wins the first tie.
REQ-018 IDLE with enable=0: stay IDLE, no grant; enable has no effect on BUSY, DONE or ERR.
REQ-019 BUSY: xaddr, xdout, memexec mirror the owner combinationally; memread = owner read; memwrite = owner write & ~owner read (read wins if both).
REQ-020 Non-owner and IDLE: every shared output 0; every mN_din, mN_ready, mN_busx of the non-owner 0.
REQ-021 mN_din = xdin whenever N is owner; mN_ready = memready only in BUSY for the owner.
REQ-022 BUSY and memready=1, busx=0: go DONE; the timeout counter clears.
REQ-023 DONE: shared strobes forced 0; leave to IDLE when owner read and write are both 0; last-served updated to owner on that exit.
REQ-024 BUSY and busx=1: go ERR; busx beats a simultaneous memready.
REQ-025 BUSY without memready: counter increments; when it reaches TIMEOUT go ERR; memready in the same cycle wins (go DONE).
REQ-026 ERR: owner mN_busx=1, shared strobes 0; exit to IDLE once busx=0 and owner read and write are both 0, minimum one cycle in ERR; last-served updated.
REQ-027 Owner dropping its strobe in BUSY before memready: abandon and go IDLE next cycle, no ready, last-served updated.
REQ-028 Counter width 8 bits, saturating; cleared on every entry to BUSY.
REQ-029 Each byte access is arbitrated independently; multi-byte transfers interleave between requesters under round robin.

Reset
REQ-030 reset=0 forces, asynchronously: state IDLE, grant 0, last-served 1, counter 0, every output 0, including mid-transaction.
REQ-031 First grant occurs no earlier than the second posedge after reset deasserts.

Verification
REQ-032 m0_read=1, addr 0x100; memready after 3 cycles, xdin 0xA5 -> xaddr=0x100, memread=1, m0_din=0xA5, m0_ready=1 for 1 cycle, grant 01 then 00.
REQ-033 m0 and m1 both request from reset -> m0 granted first, m1 next; repeated ties alternate 01,10,01.
REQ-034 m1_write, dout 0x3C, memready never -> after 15 BUSY cycles m1_busx=1 until m1 drops write; then IDLE.
REQ-035 Owner in BUSY, busx and memready both 1 same cycle -> ERR, no mN_ready pulse.
REQ-036 reset pulled low during BUSY -> all outputs 0 immediately; after release, pending m1 request granted normally.
REQ-037 enable=0 with m0_read=1 -> no grant; enable=1 -> grant 01 one cycle later.

Source files
------------

// File: rtl/gen1_arb8_if.sv
// Bus bundle between two byte requesters, the arbiter and the shared memory port.
// Handshake: a requester raises read/write and holds it with addr/dout stable until it sees ready or busx, then drops it.
interface gen1_arb8_if;
  logic        enable;
  logic [31:0] m0_addr, m1_addr;
  logic [7:0]  m0_dout, m1_dout;
  logic        m0_read, m0_write, m0_exec;
  logic        m1_read, m1_write, m1_exec;
  logic [7:0]  m0_din, m1_din;
  logic        m0_ready, m1_ready;
  logic        m0_busx, m1_busx;
  logic [31:0] xaddr;
  logic [7:0]  xdout;
  logic        memread, memwrite, memexec;
  logic [7:0]  xdin;
  logic        memready, busx;
  logic [1:0]  grant;

  modport slave (
    input  enable, m0_addr, m1_addr, m0_dout, m1_dout,
           m0_read, m0_write, m0_exec, m1_read, m1_write, m1_exec,
           xdin, memready, busx,
    output m0_din, m1_din, m0_ready, m1_ready, m0_busx, m1_busx,
           xaddr, xdout, memread, memwrite, memexec, grant
  );

  modport master (
    output enable, m0_addr, m1_addr, m0_dout, m1_dout,
           m0_read, m0_write, m0_exec, m1_read, m1_write, m1_exec,
           xdin, memready, busx,
    input  m0_din, m1_din, m0_ready, m1_ready, m0_busx, m1_busx,
           xaddr, xdout, memread, memwrite, memexec, grant
  );
endinterface

// File: rtl/gen1_arb8.sv
// Two-requester round-robin arbiter for a byte-wide shared memory port with
// completion, bus-exception and timeout handling.
module gen1_arb8 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  gen1_arb8_if.slave  bus,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        last, last_nx;
  logic        armed;
  logic [7:0]  cnt, cnt_nx, cnt_sat;
  logic        req0, req1;
  logic        own_rd, own_wr, own_ex, own_req;
  logic [31:0] own_addr;
  logic [7:0]  own_dout;
  logic        owned, rdy;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

  always_comb begin
    own_rd   = owner ? bus.m1_read  : bus.m0_read;
    own_wr   = owner ? bus.m1_write : bus.m0_write;
    own_ex   = owner ? bus.m1_exec  : bus.m0_exec;
    own_addr = owner ? bus.m1_addr  : bus.m0_addr;
    own_dout = owner ? bus.m1_dout  : bus.m0_dout;
  end

  assign own_req = own_rd | own_wr;
  assign cnt_sat = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // armed holds off arbitration for the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= 8'd0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.enable && armed && (req0 || req1)) begin
          state_nx = BUSY;
          cnt_nx   = 8'd0;
          owner_nx = (req0 && req1) ? ~last : req1;
        end
      end
      BUSY: begin
        if (!own_req) begin
          state_nx = IDLE;
          last_nx  = owner;
        end else if (bus.busx) begin
          state_nx = ERR;
        end else if (bus.memready) begin
          state_nx = DONE;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt_sat;
          if (cnt_sat >= TMO) state_nx = ERR;
        end
      end
      DONE: begin
        if (!own_req) begin
          state_nx = IDLE;
          last_nx  = owner;
        end
      end
      ERR: begin
        if (!bus.busx && !own_req) begin
          state_nx = IDLE;
          last_nx  = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign owned = (state != IDLE);
  // a dropped strobe or a simultaneous bus exception suppresses completion
  assign rdy   = (state == BUSY) && bus.memready && !bus.busx && own_req;

  always_comb begin
    bus.grant    = 2'b00;
    bus.xaddr    = 32'd0;
    bus.xdout    = 8'd0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.memexec  = 1'b0;
    bus.m0_din   = 8'd0;
    bus.m1_din   = 8'd0;
    bus.m0_ready = 1'b0;
    bus.m1_ready = 1'b0;
    bus.m0_busx  = 1'b0;
    bus.m1_busx  = 1'b0;
    if (owned) begin
      bus.grant = owner ? 2'b10 : 2'b01;
      bus.xaddr = own_addr;
      bus.xdout = own_dout;
      if (owner) bus.m1_din = bus.xdin;
      else       bus.m0_din = bus.xdin;
    end
    if (state == BUSY) begin
      bus.memread  = own_rd;
      bus.memwrite = own_wr & ~own_rd;
      bus.memexec  = own_ex;
    end
    bus.m0_ready = rdy & ~owner;
    bus.m1_ready = rdy &  owner;
    bus.m0_busx  = (state == ERR) & ~owner;
    bus.m1_busx  = (state == ERR) &  owner;
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_gen1_arb8.sv
// Randomized scoreboard bench for gen1_arb8: a transaction-level model predicts
// grant order and per-access outcome; a monitor compares observed events.
module tb_gen1_arb8;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  gen1_arb8_if bus ();

  gen1_arb8 #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // requester-side drive state
  logic [31:0] r_addr [2];
  logic [7:0]  r_dout [2];
  logic        r_rd [2];
  logic        r_wr [2];
  logic        r_ex [2];

  assign bus.m0_addr  = r_addr[0];
  assign bus.m1_addr  = r_addr[1];
  assign bus.m0_dout  = r_dout[0];
  assign bus.m1_dout  = r_dout[1];
  assign bus.m0_read  = r_rd[0];
  assign bus.m1_read  = r_rd[1];
  assign bus.m0_write = r_wr[0];
  assign bus.m1_write = r_wr[1];
  assign bus.m0_exec  = r_ex[0];
  assign bus.m1_exec  = r_ex[1];

  // per-requester planned outcome: 0 ok, 1 bus error, 2 timeout, 3 abandon
  int         oc_kind [2];
  int         oc_lat  [2];
  logic       oc_both [2];
  logic [7:0] oc_data [2];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int last_served = 1;

  logic [53:0] exp_q[$];

  function automatic logic [53:0] mk_ev(input logic [1:0] k, input logic w,
                                        input logic rd, input logic wr, input logic ex,
                                        input logic [31:0] a, input logic [7:0] d, input int c);
    return {k, w, rd, wr, ex, a, d, 8'(c)};
  endfunction

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return {31'd0, bus.grant, bus.memread, bus.memwrite, bus.memexec, bus.xaddr, bus.xdout,
            bus.m0_din, bus.m1_din, bus.m0_ready, bus.m1_ready, bus.m0_busx, bus.m1_busx};
  endfunction

  task automatic got_ev(input logic [53:0] ev);
    logic [53:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected got %h expected none", ev);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        errors++;
        $display("FAIL sb_event got %h expected %h", ev, e);
      end
    end
  endtask

  // memory responder
  int rcyc = 0;
  always begin
    int w;
    @(negedge clk);
    bus.memready = 1'b0;
    bus.busx     = 1'b0;
    bus.xdin     = 8'($urandom);
    if (bus.memread || bus.memwrite) begin
      w = bus.grant[1] ? 1 : 0;
      rcyc++;
      if (oc_kind[w] == 0 && rcyc == oc_lat[w]) begin
        bus.memready = 1'b1;
        bus.xdin     = oc_data[w];
      end else if (oc_kind[w] == 1 && rcyc == oc_lat[w]) begin
        bus.busx     = 1'b1;
        bus.memready = oc_both[w];
      end
    end else begin
      rcyc = 0;
    end
  end

  // monitor
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] prev_bx = 2'b00;
  int mcyc = 0;
  always begin
    @(negedge clk);
    #1;
    if (!mon_en) begin
      prev_grant = 2'b00;
      prev_bx    = 2'b00;
      mcyc       = 0;
    end else begin
      if (bus.grant != 2'b00 && bus.grant != prev_grant) begin
        mcyc = 0;
        got_ev(mk_ev(2'd0, bus.grant[1], 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, {30'd0, bus.grant}));
      end
      if ((bus.memread || bus.memwrite) && mcyc < 255) mcyc++;
      if (bus.m0_ready)
        got_ev(mk_ev(2'd1, 1'b0, bus.memread, bus.memwrite, bus.memexec, bus.xaddr, bus.m0_din, mcyc));
      if (bus.m1_ready)
        got_ev(mk_ev(2'd1, 1'b1, bus.memread, bus.memwrite, bus.memexec, bus.xaddr, bus.m1_din, mcyc));
      if (bus.m0_busx && !prev_bx[0])
        got_ev(mk_ev(2'd2, 1'b0, bus.memread, bus.memwrite, 1'b0, 32'd0, 8'd0, mcyc));
      if (bus.m1_busx && !prev_bx[1])
        got_ev(mk_ev(2'd2, 1'b1, bus.memread, bus.memwrite, 1'b0, 32'd0, 8'd0, mcyc));
      prev_grant = bus.grant;
      prev_bx    = {bus.m1_busx, bus.m0_busx};
    end
  end

  task automatic req_wait(input int w);
    int  n = 0;
    bit  done = 1'b0;
    logic [1:0] mine;
    mine = (w == 1) ? 2'b10 : 2'b01;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clk);
      #1;
      if (oc_kind[w] == 3) begin
        if (bus.grant == mine) begin
          n++;
          if (n == oc_lat[w]) done = 1'b1;
        end
      end else if (w == 0 ? (bus.m0_ready || bus.m0_busx) : (bus.m1_ready || bus.m1_busx)) begin
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL req_wait%0d got no completion expected one within 200 cycles", w);
    end
    @(negedge clk);
    r_rd[w] = 1'b0;
    r_wr[w] = 1'b0;
  endtask

  task automatic scenario();
    int   mask, first, n, k;
    int   order [2];
    logic p_rd [2];
    logic p_wr [2];
    bit   gate;
    mask = $urandom_range(1, 3);
    for (int w = 0; w < 2; w++) begin
      p_rd[w] = 1'b0;
      p_wr[w] = 1'b0;
      if (mask[w]) begin
        k = $urandom_range(0, 2);
        p_rd[w]    = (k != 1);
        p_wr[w]    = (k != 0);
        r_ex[w]    = 1'($urandom_range(0, 1));
        r_addr[w]  = $urandom;
        r_dout[w]  = 8'($urandom);
        oc_data[w] = 8'($urandom);
        oc_both[w] = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 9);
        if (k <= 4)      begin oc_kind[w] = 0; oc_lat[w] = $urandom_range(1, TMO); end
        else if (k <= 6) begin oc_kind[w] = 1; oc_lat[w] = $urandom_range(1, TMO - 1); end
        else if (k == 7) begin oc_kind[w] = 2; oc_lat[w] = 0; end
        else             begin oc_kind[w] = 3; oc_lat[w] = $urandom_range(1, 10); end
      end
    end
    // reference: tie goes to whoever was not served last; every access then completes in turn
    first    = (mask == 3) ? (1 - last_served) : ((mask == 2) ? 1 : 0);
    n        = (mask == 3) ? 2 : 1;
    order[0] = first;
    order[1] = 1 - first;
    for (int i = 0; i < n; i++) begin
      int w;
      w = order[i];
      exp_q.push_back(mk_ev(2'd0, 1'(w), 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, (w == 1) ? 2 : 1));
      case (oc_kind[w])
        0: exp_q.push_back(mk_ev(2'd1, 1'(w), p_rd[w], p_wr[w] & ~p_rd[w], r_ex[w],
                                 r_addr[w], oc_data[w], oc_lat[w]));
        1: exp_q.push_back(mk_ev(2'd2, 1'(w), 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, oc_lat[w]));
        2: exp_q.push_back(mk_ev(2'd2, 1'(w), 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, TMO));
        default: ;
      endcase
      last_served = w;
    end
    gate = ($urandom_range(0, 3) == 0);
    @(negedge clk);
    if (gate) bus.enable = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (mask[w]) begin
        r_rd[w] = p_rd[w];
        r_wr[w] = p_wr[w];
      end
    end
    if (gate) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #1;
      chk("gate_off_grant", 96'(bus.grant), 96'd0);
      @(negedge clk);
      bus.enable = 1'b1;
    end
    fork
      begin if (mask[0]) req_wait(0); end
      begin if (mask[1]) req_wait(1); end
    join
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      r_addr[w] = 32'hDEAD_0000 + 32'(w);
      r_dout[w] = 8'h5A;
      r_rd[w] = 1'b0; r_wr[w] = 1'b0; r_ex[w] = 1'b1;
      oc_kind[w] = 2; oc_lat[w] = 0; oc_both[w] = 1'b0; oc_data[w] = 8'h00;
    end
    bus.enable   = 1'b1;
    bus.memready = 1'b0;
    bus.busx     = 1'b0;
    bus.xdin     = 8'hFF;

    // reset state, even with a request pending
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", all_outs(), 96'd0);
    chk("reset_state", 96'(dbg_state), 96'd0);
    r_rd[0] = 1'b1; r_addr[0] = 32'h100;
    @(negedge clk);
    #1;
    chk("reset_hold_outs", all_outs(), 96'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("first_edge_grant", 96'(bus.grant), 96'd0);
    @(negedge clk);
    #1;
    chk("second_edge_grant", 96'(bus.grant), 96'b01);
    chk("busy_port", 96'({bus.xaddr, bus.memread, bus.memwrite, bus.memexec}), 96'({32'h100, 3'b101}));
    r_rd[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("abandon_idle", 96'({dbg_state, bus.grant}), 96'd0);

    // enable gating
    bus.enable = 1'b0;
    r_rd[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("enable_off_grant", 96'(bus.grant), 96'd0);
    bus.enable = 1'b1;
    @(negedge clk);
    #1;
    chk("enable_on_grant", 96'(bus.grant), 96'b01);
    r_rd[0] = 1'b0;
    repeat (2) @(negedge clk);

    // asynchronous reset in the middle of a write, m1 left pending
    r_wr[0] = 1'b1; r_dout[0] = 8'h3C;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_reset_grant", 96'(bus.grant), 96'b01);
    r_rd[1] = 1'b1; r_addr[1] = 32'h200;
    #1;
    reset = 1'b0;
    #1;
    chk("midbusy_reset_outs", all_outs(), 96'd0);
    chk("midbusy_reset_state", 96'(dbg_state), 96'd0);
    r_wr[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_edge1", 96'(bus.grant), 96'd0);
    @(negedge clk);
    #1;
    chk("post_reset_m1_grant", 96'(bus.grant), 96'b10);
    r_rd[1] = 1'b0;
    repeat (3) @(negedge clk);

    // randomized section from a fresh reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    last_served = 1;
    mon_en = 1'b1;
    for (int s = 0; s < 60; s++) scenario();
    repeat (5) @(negedge clk);
    chk("queue_empty", 96'(exp_q.size()), 96'd0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
